trivium_stream: RTL and testbench
=================================

Name: trivium_stream

Overview:
- Parametrised successor to the 1-bit Trivium core.
- Runs W Trivium steps per clock.
- Encrypts or decrypts a valid/ready data stream word by word, by XOR with keystream, for a programmable word count.
- Sits between the host key/IV registers and the data FIFO path; one instance per channel.

Parameters:
- W, 8, keystream/data bits per cycle; legal values 1, 2, 4, 8, 16, 32, 64, all of which divide 1152.
- LENW, 16, width of the word-count input.

Ports:
- CLK  in  1  system clock.
- RSTn  in  1  reset. Asynchronous, active-low.
- EN  in  1  global enable. When low, all state, counters and outputs hold.
- Kin  in  80  key. Byte-reversed before load: Kin[7:0] is the most significant byte.
- Din_iv  in  80  IV. Same byte reversal as Kin.
- Len  in  LENW  number of W-bit words to process. 0 is legal.
- Krdy  in  1  load Kin/Din_iv/Len and start initialisation.
- Kvld  out  1  one-cycle pulse: key/IV accepted.
- BSY  out  1  high from load until DONE.
- din  in  W  plaintext/ciphertext word.
- din_valid  in  1  din qualifier.
- din_ready  out  1  block accepts din.
- dout  out  W  din XOR keystream.
- dout_valid  out  1  dout qualifier.
- dout_ready  in  1  sink accepts dout.
- Dvld  out  1  one-cycle pulse: Len words delivered.

Behaviour:
- Reset (async, RSTn=0):
  - state := IDLE; all outputs 0; Trivium register := 0; counters := 0.
- Internal state s1..s288; step function is standard Trivium:
  - t1=s66^s93, t2=s162^s177, t3=s243^s288, z=t1^t2^t3.
  - Shifts take feedback t1^s91&s92^s171, t2^s175&s176^s264, t3^s286&s287^s69.
- Load: s1..s80 = reversed key, s94..s173 = reversed IV, s286..s288 = 1, all other bits 0.
- Per cycle W steps are unrolled. The keystream bit of step j (j=0 first) XORs din[j].
- FSM:
  - IDLE:
    - Krdy=1 -> latch inputs, load state, Kvld=1 next cycle, BSY=1, go INIT.
    - Krdy is ignored in all other states.
  - INIT:
    - Advances W steps per cycle, discarding z, for 1152/W cycles.
    - Then -> RUN, or -> DONE if Len=0.
  - RUN:
    - din_ready = !dout_valid | dout_ready.
    - On a din_valid & din_ready transfer:
      - dout <= din ^ ks and dout_valid <= 1 (latency 1 cycle).
      - The state advances W steps and the word count decrements.
    - No transfer -> the Trivium state holds.
    - dout_valid clears on dout_ready when no new word is loaded that cycle.
    - Full throughput: 1 word/cycle with dout_ready held high.
  - Last word:
    - After the last word is accepted -> DONE.
    - dout_valid stays asserted until that word is consumed.
  - DONE:
    - Waits until !dout_valid, then pulses Dvld=1 for one cycle, clears BSY, goes IDLE.
- din_ready is 0 outside RUN.
- Count register is LENW bits. The bound is Len; it never wraps.
- EN=0:
  - din_ready=0; dout/dout_valid hold; Kvld/Dvld pulses are delayed, not lost.
- Encryption and decryption are identical operations.
- Async reset mid-stream aborts immediately. There is no partial Dvld.

Optional Feature:
- Macro: TRIVIUM_IV_RESYNC_EN.
- When defined:
  - Adds input Irdy.
  - The latched key is retained in an 80-bit register.
  - In IDLE, Irdy=1 with Krdy=0 reloads only Din_iv and Len, reuses the stored key, pulses Kvld, and enters INIT.
  - Krdy has priority if both are high.
  - Before any Krdy since reset, the stored key is 0.
- When undefined:
  - There is no Irdy port and no key register.
  - Only Krdy starts a session.

Test Plan:
- W=1, key=0, IV=0, Len=64, din=0, dout_ready=1:
  - Kvld one cycle after Krdy; INIT 1152 cycles.
  - The 64 dout bits equal the golden 1-bit core keystream.
  - Dvld pulses once.
- W=8, same key/IV as above, Len=8, din=0:
  - INIT lasts 144 cycles.
  - dout bytes equal the W=1 keystream packed LSB-first.
- W=32, random key/IV, Len=16, random dout_ready stalls:
  - No word lost or duplicated.
  - Re-running with dout as din recovers the original plaintext.
- Len=0:
  - Kvld, then INIT, then Dvld.
  - dout_valid never asserts.
  - BSY falls the cycle after Dvld.
- Assert RSTn=0 at word 5 of Len=10:
  - All outputs 0 immediately.
  - A subsequent Krdy session produces the correct keystream from word 0.
- TRIVIUM_IV_RESYNC_EN:
  - Krdy with key K/IV A, then Irdy with IV B.
  - Output equals a fresh Krdy session with K/B.
  - Irdy before any Krdy uses key 0.

Source files
------------

// File: rtl/trivium_stream_if.sv
// Valid/ready data stream between the channel FIFO path and trivium_stream.
// The host side drives din and dout_ready; the cipher block answers with din_ready and dout.
interface trivium_stream_if #(
    parameter int W = 8
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid
    );
endinterface

// File: rtl/trivium_stream.sv
// W-bit-per-cycle Trivium stream cipher: XORs a word-counted valid/ready stream with keystream.
// Optional macro TRIVIUM_IV_RESYNC_EN adds Irdy, restarting from a stored key with a new IV.
//
// state | meaning
// IDLE  | waiting for Krdy (or Irdy); finishes clearing BSY/Dvld after a session
// INIT  | 1152 warm-up steps, W per cycle, keystream discarded
// RUN   | one keystream word per accepted din word
// DONE  | waits for the last dout to drain, then pulses Dvld
module trivium_stream #(
    parameter int W    = 8,
    parameter int LENW = 16
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            EN,
    input  logic [79:0]     Kin,
    input  logic [79:0]     Din_iv,
    input  logic [LENW-1:0] Len,
    input  logic            Krdy,
`ifdef TRIVIUM_IV_RESYNC_EN
    input  logic            Irdy,
`endif
    output logic            Kvld,
    output logic            BSY,
    output logic            Dvld,
    trivium_stream_if.slave st
);
    localparam int          INIT_CYC  = 1152 / W;
    localparam logic [10:0] INIT_LAST = 11'(INIT_CYC - 1);

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    state_t          state_q;
    logic [287:0]    triv_q;
    logic [287:0]    triv_d;
    logic [287:0]    s_w;
    logic [W-1:0]    ks_d;
    logic [10:0]     icnt_q;
    logic [LENW-1:0] wcnt_q;
    logic            kvld_q;
    logic            bsy_q;
    logic            dvld_q;
    logic [W-1:0]    dout_q;
    logic            dout_valid_q;
    logic            start;
    logic [79:0]     load_key;
    logic            xfer;

    // Host registers hold the first byte in [7:0]; the cipher wants it most significant.
    function automatic logic [79:0] byte_rev(input logic [79:0] v);
        logic [79:0] r;
        for (int b = 0; b < 10; b++) r[8*b +: 8] = v[8*(9-b) +: 8];
        return r;
    endfunction

    // Index i holds Trivium bit s(i+1).
    function automatic logic [287:0] triv_load(input logic [79:0] k, input logic [79:0] iv);
        logic [287:0] s;
        s           = '0;
        s[79:0]     = k;
        s[172:93]   = iv;
        s[287:285]  = 3'b111;
        return s;
    endfunction

    function automatic logic triv_z(input logic [287:0] s);
        return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
    endfunction

    function automatic logic [287:0] triv_step(input logic [287:0] s);
        logic a, b, c;
        a = s[65]  ^ s[92]  ^ (s[90]  & s[91])  ^ s[170];
        b = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
        c = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
        return {s[286:177], b, s[175:93], a, s[91:0], c};
    endfunction

    always_comb begin
        s_w  = triv_q;
        ks_d = '0;
        for (int j = 0; j < W; j++) begin
            ks_d[j] = triv_z(s_w);
            s_w     = triv_step(s_w);
        end
        triv_d = s_w;
    end

`ifdef TRIVIUM_IV_RESYNC_EN
    logic [79:0] key_q;

    // Krdy wins over Irdy; a resync reuses whatever key the last Krdy stored.
    always_comb begin
        start    = Krdy | Irdy;
        load_key = Krdy ? byte_rev(Kin) : key_q;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            key_q <= '0;
        end else if (EN && state_q == IDLE && Krdy) begin
            key_q <= byte_rev(Kin);
        end
    end
`else
    always_comb begin
        start    = Krdy;
        load_key = byte_rev(Kin);
    end
`endif

    assign st.din_ready = EN && (state_q == RUN) && (!dout_valid_q || st.dout_ready);
    assign xfer         = st.din_valid && st.din_ready;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= IDLE;
            triv_q       <= '0;
            icnt_q       <= '0;
            wcnt_q       <= '0;
            kvld_q       <= 1'b0;
            bsy_q        <= 1'b0;
            dvld_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else if (EN) begin
            case (state_q)
                IDLE: begin
                    kvld_q <= 1'b0;
                    dvld_q <= 1'b0;
                    bsy_q  <= 1'b0;
                    if (start) begin
                        triv_q  <= triv_load(load_key, byte_rev(Din_iv));
                        wcnt_q  <= Len;
                        icnt_q  <= INIT_LAST;
                        kvld_q  <= 1'b1;
                        bsy_q   <= 1'b1;
                        state_q <= INIT;
                    end
                end
                INIT: begin
                    kvld_q <= 1'b0;
                    triv_q <= triv_d;
                    if (icnt_q == '0) begin
                        state_q <= (wcnt_q == '0) ? DONE : RUN;
                    end else begin
                        icnt_q <= icnt_q - 11'd1;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        dout_q       <= st.din ^ ks_d;
                        dout_valid_q <= 1'b1;
                        triv_q       <= triv_d;
                        wcnt_q       <= wcnt_q - LENW'(1);
                        if (wcnt_q == LENW'(1)) state_q <= DONE;
                    end else if (st.dout_ready) begin
                        dout_valid_q <= 1'b0;
                    end
                end
                DONE: begin
                    // BSY stays up through the Dvld cycle and drops on the way out of IDLE.
                    if (!dout_valid_q) begin
                        dvld_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (st.dout_ready) begin
                        dout_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Kvld          = kvld_q;
    assign BSY           = bsy_q;
    assign Dvld          = dvld_q;
    assign st.dout       = dout_q;
    assign st.dout_valid = dout_valid_q;
endmodule

// File: tb/tb_trivium_stream.sv
// Scoreboard bench for trivium_stream: a bit-serial Trivium model predicts every dout word.
// Resync sessions are exercised when TRIVIUM_IV_RESYNC_EN is defined.
module tb_trivium_stream;
    localparam int W        = 8;
    localparam int LENW     = 16;
    localparam int INIT_CYC = 1152 / W;

    logic            CLK = 1'b0;
    logic            RSTn = 1'b0;
    logic            EN = 1'b0;
    logic [79:0]     Kin = '0;
    logic [79:0]     Din_iv = '0;
    logic [LENW-1:0] Len = '0;
    logic            Krdy = 1'b0;
    logic            Kvld, BSY, Dvld;
`ifdef TRIVIUM_IV_RESYNC_EN
    logic            Irdy = 1'b0;
`endif

    trivium_stream_if #(.W(W)) sif ();

    trivium_stream #(.W(W), .LENW(LENW)) dut (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .EN     (EN),
        .Kin    (Kin),
        .Din_iv (Din_iv),
        .Len    (Len),
        .Krdy   (Krdy),
`ifdef TRIVIUM_IV_RESYNC_EN
        .Irdy   (Irdy),
`endif
        .Kvld   (Kvld),
        .BSY    (BSY),
        .Dvld   (Dvld),
        .st     (sif)
    );

    always #5 CLK = ~CLK;

    int           n_chk = 0;
    int           n_err = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] pt_q[$];
    logic [W-1:0] rx_q[$];
    bit [288:1]   m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] brev(input logic [79:0] v);
        logic [79:0] r;
        for (int b = 0; b < 10; b++) r[8*b +: 8] = v[8*(9-b) +: 8];
        return r;
    endfunction

    task automatic m_load(input logic [79:0] k, input logic [79:0] iv);
        logic [79:0] kr, ivr;
        kr  = brev(k);
        ivr = brev(iv);
        m   = '0;
        for (int i = 1; i <= 80; i++) begin
            m[i]      = kr[i-1];
            m[93 + i] = ivr[i-1];
        end
        m[286] = 1'b1;
        m[287] = 1'b1;
        m[288] = 1'b1;
    endtask

    task automatic m_step(output bit z);
        bit t1, t2, t3;
        t1 = m[66]  ^ m[93];
        t2 = m[162] ^ m[177];
        t3 = m[243] ^ m[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (m[91]  & m[92])  ^ m[171];
        t2 = t2 ^ (m[175] & m[176]) ^ m[264];
        t3 = t3 ^ (m[286] & m[287]) ^ m[69];
        m  = {m[287:178], t2, m[176:94], t1, m[92:1], t3};
    endtask

    task automatic m_word(output logic [W-1:0] ks);
        bit z;
        for (int j = 0; j < W; j++) begin
            m_step(z);
            ks[j] = z;
        end
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_kvld"}, 64'(Kvld), 64'd0);
        chk({pfx, "_bsy"}, 64'(BSY), 64'd0);
        chk({pfx, "_dvld"}, 64'(Dvld), 64'd0);
        chk({pfx, "_dout_valid"}, 64'(sif.dout_valid), 64'd0);
        chk({pfx, "_dout"}, 64'(sif.dout), 64'd0);
        chk({pfx, "_din_ready"}, 64'(sif.din_ready), 64'd0);
    endtask

    // k is the key the session is expected to run with; with use_irdy the DUT sees ~k on Kin.
    task automatic run_session(input logic [79:0] k, input logic [79:0] iv, input int len,
                               input int stall, input int abort_at, input bit use_ct,
                               input bit rand_en, input bit use_irdy);
        int           n, cyc, sent, rcv;
        bit           done, took, z;
        logic [W-1:0] ks, exp_w;
        sb.delete();
        if (!use_ct) begin
            pt_q.delete();
            rx_q.delete();
        end
        sent = 0; rcv = 0; cyc = 0; done = 0; took = 0;
        @(negedge CLK);
        EN = 1'b1;
        Kin = use_irdy ? ~k : k;
        Din_iv = iv;
        Len = LENW'(len);
        sif.din_valid = 1'b0;
        sif.dout_ready = 1'b1;
`ifdef TRIVIUM_IV_RESYNC_EN
        if (use_irdy) Irdy = 1'b1; else Krdy = 1'b1;
`else
        Krdy = 1'b1;
`endif
        @(negedge CLK);
        Krdy = 1'b0;
`ifdef TRIVIUM_IV_RESYNC_EN
        Irdy = 1'b0;
`endif
        chk("kvld_pulse", 64'(Kvld), 64'd1);
        chk("bsy_load", 64'(BSY), 64'd1);
        m_load(k, iv);
        repeat (1152) m_step(z);
        @(negedge CLK);
        n = 1;
        chk("kvld_single", 64'(Kvld), 64'd0);
        while (!(sif.din_ready || Dvld) && n < 2 * INIT_CYC + 10) begin
            @(negedge CLK);
            n++;
        end
        chk("init_cycles", 64'(n), 64'(len == 0 ? INIT_CYC + 1 : INIT_CYC));

        while (!done && cyc < 4000) begin
            if (took) sif.din_valid = 1'b0;
            took = 0;
            EN = rand_en ? ($urandom_range(0, 7) != 0) : 1'b1;
            sif.dout_ready = ($urandom_range(0, 99) >= stall);
            if (!sif.din_valid && sent < len && $urandom_range(0, 3) != 0) begin
                sif.din_valid = 1'b1;
                sif.din = use_ct ? rx_q[sent] : W'({$urandom, $urandom});
            end
            #1;
            if (Dvld && EN) done = 1;
            if (EN && sif.dout_valid && sif.dout_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_dout", 64'(sif.dout_valid), 64'd0);
                end else begin
                    exp_w = sb.pop_front();
                    chk("dout", 64'(sif.dout), 64'(exp_w));
                    if (use_ct) chk("roundtrip", 64'(sif.dout), 64'(pt_q[rcv]));
                    else rx_q.push_back(sif.dout);
                    rcv++;
                end
            end
            if (sif.din_valid && sif.din_ready) begin
                m_word(ks);
                sb.push_back(sif.din ^ ks);
                if (!use_ct) pt_q.push_back(sif.din);
                sent++;
                took = 1;
                if (abort_at != 0 && sent == abort_at) break;
            end
            @(negedge CLK);
            cyc++;
        end

        if (abort_at != 0) begin
            chk("abort_reached", 64'(sent), 64'(abort_at));
            RSTn = 1'b0;
            #1;
            check_all_zero("abort");
            sif.din_valid = 1'b0;
            EN = 1'b1;
            @(negedge CLK);
            RSTn = 1'b1;
        end else begin
            chk("dvld_seen", 64'(done), 64'd1);
            chk("rx_count", 64'(rcv), 64'(len));
            chk("sb_empty", 64'(sb.size()), 64'd0);
            chk("bsy_after_dvld", 64'(BSY), 64'd0);
            chk("dvld_one_cycle", 64'(Dvld), 64'd0);
            chk("dout_valid_idle", 64'(sif.dout_valid), 64'd0);
            sif.din_valid = 1'b0;
            EN = 1'b1;
        end
    endtask

    logic [79:0] k1, k2, iv1, iv2;

    initial begin
        sif.din = '0;
        sif.din_valid = 1'b0;
        sif.dout_ready = 1'b0;
        k1  = {$urandom, $urandom, $urandom};
        k2  = {$urandom, $urandom, $urandom};
        iv1 = {$urandom, $urandom, $urandom};
        iv2 = {$urandom, $urandom, $urandom};
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RSTn = 1'b1;
        EN = 1'b1;
        @(negedge CLK);

        run_session(80'd0, 80'd0, 8, 0, 0, 1'b0, 1'b0, 1'b0);
        run_session(k1, iv1, 16, 40, 0, 1'b0, 1'b1, 1'b0);
        run_session(k1, iv1, 16, 40, 0, 1'b1, 1'b1, 1'b0);
        run_session(k1, iv2, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_session(k2, iv2, 10, 20, 5, 1'b0, 1'b0, 1'b0);
        run_session(k2, iv2, 10, 20, 0, 1'b0, 1'b1, 1'b0);

`ifdef TRIVIUM_IV_RESYNC_EN
        @(negedge CLK);
        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        run_session(80'd0, iv1, 8, 10, 0, 1'b0, 1'b0, 1'b1);
        run_session(k1, iv1, 4, 0, 0, 1'b0, 1'b0, 1'b0);
        run_session(k1, iv2, 8, 30, 0, 1'b0, 1'b1, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
